// File: rtl/ex_mem_stage_if.sv
// EX->MEM pipeline bus: EX-side inputs, MEM-side outputs and fetch redirect.
interface ex_mem_stage_if;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] rt_data;
  logic [4:0]  rd;
  logic        is_branch;
  logic        is_jr;
  logic        mem_we;
  logic        mem_re;
  logic        reg_we;
  logic        stall;
  logic        flush;

  logic        mem_valid;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_store_data;
  logic        mem_mem_we;
  logic        mem_mem_re;
  logic        mem_reg_we;
  logic [4:0]  mem_rd;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output ex_valid, ex_pc, ex_imm, alu_result, alu_zero, rt_data, rd,
           is_branch, is_jr, mem_we, mem_re, reg_we, stall, flush,
    input  mem_valid, mem_alu_result, mem_store_data, mem_mem_we,
           mem_mem_re, mem_reg_we, mem_rd, redirect, redirect_pc
  );

  modport slave (
    input  ex_valid, ex_pc, ex_imm, alu_result, alu_zero, rt_data, rd,
           is_branch, is_jr, mem_we, mem_re, reg_we, stall, flush,
    output mem_valid, mem_alu_result, mem_store_data, mem_mem_we,
           mem_mem_re, mem_reg_we, mem_rd, redirect, redirect_pc
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jr resolution and a one-cycle
// fetch redirect; the instruction following a redirect is squashed.
module ex_mem_stage (
  input  logic           clk,
  input  logic           rst_n,
  ex_mem_stage_if.slave  bus
);

  typedef enum logic {NORMAL, REDIR} state_t;

  state_t      state, state_next;
  logic        taken;
  logic [31:0] target;
  logic        advance;
  logic        live;

  // jr wins over a simultaneous branch; branch target wraps mod 2^32
  assign taken   = bus.ex_valid & (bus.is_jr | (bus.is_branch & bus.alu_zero));
  assign target  = bus.is_jr ? bus.alu_result
                             : bus.ex_pc + 32'd4 + {bus.ex_imm[29:0], 2'b00};
  assign advance = ~bus.flush & ~bus.stall;
  assign live    = advance & (state == NORMAL) & bus.ex_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NORMAL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = NORMAL;
    end else if (!bus.stall) begin
      unique case (state)
        NORMAL:  if (taken) state_next = REDIR;
        REDIR:   state_next = NORMAL;
        default: state_next = NORMAL;
      endcase
    end
  end

  // redirect is decoded from state so an async reset drops it immediately
  assign bus.redirect = (state == REDIR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_valid      <= 1'b0;
      bus.mem_alu_result <= '0;
      bus.mem_store_data <= '0;
      bus.mem_mem_we     <= 1'b0;
      bus.mem_mem_re     <= 1'b0;
      bus.mem_reg_we     <= 1'b0;
      bus.mem_rd         <= '0;
      bus.redirect_pc    <= '0;
    end else if (bus.flush) begin
      bus.mem_valid  <= 1'b0;
      bus.mem_mem_we <= 1'b0;
      bus.mem_mem_re <= 1'b0;
      bus.mem_reg_we <= 1'b0;
    end else if (!bus.stall) begin
      // wrong-path or invalid EX instructions become bubbles via live=0
      bus.mem_valid      <= live;
      bus.mem_mem_we     <= live & bus.mem_we;
      bus.mem_mem_re     <= live & bus.mem_re;
      bus.mem_reg_we     <= live & bus.reg_we;
      bus.mem_alu_result <= bus.alu_result;
      bus.mem_store_data <= bus.rt_data;
      bus.mem_rd         <= bus.rd;
      if (state == NORMAL && taken) bus.redirect_pc <= target;
    end
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have EX inputs: ex_valid in 1 instr valid; ex_pc in 32 instr PC; ex_imm in 32 sign-extended imm; alu_result in 32; alu_zero in 1; rt_data in 32 store data; rd in 5 dest reg.
REQ-003 SHALL have EX control inputs, 1 bit each: is_branch (any conditional branch); is_jr (jr/jalr); mem_we; mem_re; reg_we.
REQ-004 SHALL have pipeline control inputs: stall in 1 hold stage; flush in 1 squash stage.
REQ-005 SHALL have MEM outputs: mem_valid 1; mem_alu_result 32; mem_store_data 32; mem_mem_we 1; mem_mem_re 1; mem_reg_we 1; mem_rd 5.
REQ-006 SHALL have fetch outputs: redirect out 1 PC-redirect request; redirect_pc out 32 target.

Function
REQ-007 Priority at each rising edge SHALL be flush > stall > capture.
REQ-008 Capture: the cycle after ex_valid=1 with stall=0 and flush=0, all MEM outputs SHALL equal the EX inputs of the capture cycle. mem_store_data SHALL equal rt_data; mem_valid SHALL equal 1. Latency is 1 cycle.
REQ-009 Squashed capture: mem_valid, mem_mem_we, mem_mem_re and mem_reg_we SHALL all be 0. Data outputs are don't-care.
REQ-010 Stall: all registered outputs and FSM state SHALL hold their values.
REQ-011 Flush: MEM side SHALL become a bubble per REQ-009. FSM SHALL return to NORMAL. redirect SHALL be 0 the next cycle.
REQ-012 Branch taken SHALL be ex_valid & is_branch & alu_zero. Zero=1 means the condition held.
REQ-013 Branch target SHALL be ex_pc + 4 + (ex_imm << 2), computed modulo 2^32 with no overflow detection.
REQ-014 A jr/jalr SHALL always redirect. Its target SHALL be alu_result, which the ALU passes through from A.
REQ-015 If is_branch and is_jr are both 1, is_jr SHALL win.
REQ-016 FSM SHALL have states NORMAL and REDIR.
REQ-017 NORMAL -> REDIR SHALL occur on capture of a taken branch or jr. The capturing instruction itself SHALL still be passed to MEM valid, because the link write of jalr needs it.
REQ-018 In REDIR: redirect=1, with redirect_pc holding the registered target. The instruction presented on EX that cycle is wrong-path: when stall=0 it SHALL be captured as a bubble (REQ-009), and the FSM SHALL go to NORMAL regardless of whether it is a branch.
REQ-019 REDIR with stall=1 SHALL hold redirect=1 and redirect_pc until stall drops.
REQ-020 redirect SHALL never be asserted in NORMAL. A redirect pulse SHALL last exactly one unstalled cycle.
REQ-021 A taken branch arriving in REDIR SHALL be ignored, because it is wrong-path.
REQ-022 ex_valid=0 with stall=0 and flush=0 SHALL capture a bubble. The FSM SHALL remain in NORMAL.

Reset
REQ-023 Asserting rst_n=0 SHALL, asynchronously and immediately, clear every output to 0 and force the FSM to NORMAL. This includes reset asserted mid-REDIR: redirect SHALL drop without waiting for clk.
REQ-024 Release of rst_n SHALL take effect at the next rising clk. The first capture SHALL follow normal rules.

Verification
REQ-025 Plain capture: ex_valid=1, alu_result=0x0000_1234, rd=5, reg_we=1 -> next cycle mem_alu_result=0x1234, mem_rd=5, mem_reg_we=1, mem_valid=1, redirect=0.
REQ-026 beq taken: ex_pc=0x0040_0010, ex_imm=0xFFFF_FFFC, is_branch=1, alu_zero=1 -> next cycle redirect=1, redirect_pc=0x0040_0004. The following EX instr is captured with mem_valid=0. Redirect is 0 one cycle later.
REQ-027 jr with stall: is_jr=1, alu_result=0x0040_0100, then stall=1 for 3 cycles -> redirect=1 and redirect_pc=0x0040_0100 held 4 cycles total. The MEM regs are unchanged during the stall.
REQ-028 Wrap-around: ex_pc=0xFFFF_FFF8, ex_imm=0x1, taken -> redirect_pc=0x0000_0000.
REQ-029 flush+stall simultaneously while in REDIR with mem_mem_we=1 -> next cycle mem_valid=0, mem_mem_we=0, redirect=0.
REQ-030 Async reset: drive rst_n low between clock edges while redirect=1 -> redirect and all outputs read 0 before the next clk edge.
